row_buf: RTL and testbench
==========================

ROW_BUF -- requirements
Module: row_buf

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous active-high reset, sampled on rising clk edge.
REQ-003 SHALL have port: load  in  1  one-cycle word strobe from the upstream serial-to-parallel stage.
REQ-004 SHALL have port: din  in  70  word accompanying load.
REQ-005 SHALL have port: row  in  4  row index accompanying load; legal values 1..12.
REQ-006 SHALL have port: out_ready  in  1  downstream accepts the current word.
REQ-007 SHALL have port: clr_err  in  1  clears the sticky error flag.
REQ-008 SHALL have port: out_valid  out  1  out_data/out_row hold a valid word.
REQ-009 SHALL have port: out_data  out  70  buffered word being presented.
REQ-010 SHALL have port: out_row  out  4  row index (1..12) of out_data.
REQ-011 SHALL have port: frame_done  out  1  one-cycle pulse when row 12 of a frame is stored.
REQ-012 SHALL have port: seq_err  out  1  sticky error: out-of-sequence row, illegal row, or overrun.
REQ-013 SHALL have port: busy  out  1  high while in DRAIN.

Function
REQ-014 SHALL hold a 12 x 70-bit buffer, entry k holding row k+1.
REQ-015 SHALL implement FSM states FILL and DRAIN; reset state FILL.
REQ-016 FILL: SHALL keep expected-row counter exp (1..12, reset 1).
REQ-017 FILL, load=1, row==exp: SHALL write din to entry row-1 and advance exp by 1.
REQ-018 FILL, load=1, row==12==exp: SHALL write the entry, pulse frame_done the next cycle, enter DRAIN the next cycle, and reset exp to 1.
REQ-019 FILL, load=1, row!=exp, row==1: SHALL set seq_err, restart the frame by writing entry 0, and set exp=2.
REQ-020 FILL, load=1, row!=exp, row!=1 (including 0 and 13..15): SHALL set seq_err, drop the word, and leave exp unchanged.
REQ-021 DRAIN: SHALL assert out_valid with out_data=entry rd, out_row=rd+1; rd starts at 0.
REQ-022 DRAIN: out_valid SHALL stay high and out_data/out_row stable until out_valid&&out_ready.
REQ-023 DRAIN handshake with rd<11: SHALL advance rd by 1, keeping out_valid high the next cycle with no bubble.
REQ-024 DRAIN handshake with rd==11: SHALL return to FILL, deassert out_valid the next cycle, and reset rd to 0.
REQ-025 DRAIN, load=1: overrun; SHALL set seq_err and drop the word, leaving buffer and FSM unaffected.
REQ-026 Latency: a load of row 12 in cycle N SHALL give out_valid=1 with row 1 data in cycle N+1.
REQ-027 FILL: out_valid SHALL be 0; out_data/out_row SHALL hold their last values.
REQ-028 clr_err=1 SHALL clear seq_err; a simultaneous error event SHALL take priority and leave seq_err=1.
REQ-029 busy SHALL equal (state==DRAIN).
REQ-030 load SHALL be ignored when rst=1.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 rst SHALL force: state FILL, exp=1, rd=0, out_valid=0, out_data=0, out_row=0, frame_done=0, seq_err=0, busy=0.
REQ-033 Buffer contents SHALL NOT require reset.
REQ-034 rst mid-FILL or mid-DRAIN SHALL abandon the partial frame; the next frame starts at row 1.

Structure
REQ-035 Shared package SHALL hold: ROW_W=70, N_ROWS=12, ROW_IDX_W=4, and the FSM state enumeration.
REQ-036 The 12x70 storage SHALL be a sub-module row_mem: 1 write port, 1 combinational read port, no reset.

Verification
REQ-037 The bench SHALL cover: loads of rows 1..12 with din=row*0x111 and out_ready=1 -> frame_done one cycle after row 12; out_row 1..12 on 12 consecutive cycles; data matches; seq_err=0.
REQ-038 The bench SHALL cover: full frame with out_ready toggled 1,0,0,1,... -> out_data/out_row stable while stalled; all 12 words delivered in order; busy falls the cycle after the row-12 handshake.
REQ-039 The bench SHALL cover: rows 1,2,4 -> seq_err=1 after row 4 and row 4 dropped; then rows 3..12 -> frame completes normally.
REQ-040 The bench SHALL cover: rows 1..5 then row 1 then rows 2..12 -> seq_err=1; the drained frame holds the post-restart row 1 data.
REQ-041 The bench SHALL cover: load during DRAIN with out_ready=0 -> seq_err=1 and drain data unchanged; clr_err pulse -> seq_err=0 next cycle.
REQ-042 The bench SHALL cover: rst asserted after row 7 -> all outputs at reset values next cycle; new rows 1..12 -> normal frame.

Source files
------------

// File: rtl/row_buf_pkg.sv
// Shared widths and FSM encoding for the row buffer block.
package row_buf_pkg;
  localparam int ROW_W     = 70;
  localparam int N_ROWS    = 12;
  localparam int ROW_IDX_W = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/row_buf_mem.sv
// 12-entry row storage: one write port, one combinational read port, no reset.
module row_mem
  import row_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [ROW_IDX_W-1:0] waddr,
  input  logic [ROW_W-1:0]     wdata,
  input  logic [ROW_IDX_W-1:0] raddr,
  output logic [ROW_W-1:0]     rdata
);
  logic [ROW_W-1:0] mem [N_ROWS];

  // Write port; contents are only meaningful once a row has been stored.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/row_buf.sv
// Collects rows 1..12 of a frame, then presents them one per handshake.
module row_buf
  import row_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ROW_W-1:0]     din,
  input  logic [ROW_IDX_W-1:0] row,
  input  logic                 out_ready,
  input  logic                 clr_err,
  output logic                 out_valid,
  output logic [ROW_W-1:0]     out_data,
  output logic [ROW_IDX_W-1:0] out_row,
  output logic                 frame_done,
  output logic                 seq_err,
  output logic                 busy
);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(N_ROWS);
  localparam logic [ROW_IDX_W-1:0] LAST_RD  = ROW_IDX_W'(N_ROWS - 1);

  state_t               state, state_nxt;
  logic [ROW_IDX_W-1:0] exp_q;   // next row expected in FILL (1..12)
  logic [ROW_IDX_W-1:0] rd_q;    // entry currently presented in DRAIN (0..11)

  logic                 in_seq, restart, err_evt, last_row, hs, hs_last;
  logic                 mem_we;
  logic [ROW_IDX_W-1:0] mem_waddr, mem_raddr;
  logic [ROW_W-1:0]     mem_rdata;

  // Event decode for the current cycle.
  always_comb begin
    in_seq   = load && (state == FILL) && (row == exp_q);
    restart  = load && (state == FILL) && (row != exp_q) && (row == 4'd1);
    err_evt  = load && ((state == DRAIN) || (row != exp_q));
    last_row = in_seq && (exp_q == LAST_ROW);
    hs       = (state == DRAIN) && out_valid && out_ready;
    hs_last  = hs && (rd_q == LAST_RD);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_row) state_nxt = DRAIN;
      DRAIN:   if (hs_last)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Storage port control. In FILL the read port pre-fetches entry 0 so the
  // first word is ready the cycle after row 12 lands; in DRAIN it looks ahead
  // to the following entry so handshakes stream without bubbles.
  always_comb begin
    mem_we    = (in_seq || restart) && !rst;
    mem_waddr = row - 4'd1;
    mem_raddr = '0;
    if (state == DRAIN && rd_q != LAST_RD) mem_raddr = rd_q + 4'd1;
  end

  row_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (din),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Sequence counters, output word register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= 4'd1;
      rd_q       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      frame_done <= last_row;
      // An error in the same cycle as clr_err wins.
      if (err_evt)      seq_err <= 1'b1;
      else if (clr_err) seq_err <= 1'b0;

      if (state == FILL) begin
        if (last_row) begin
          exp_q     <= 4'd1;
          out_valid <= 1'b1;
          out_data  <= mem_rdata;
          out_row   <= 4'd1;
        end else if (in_seq) begin
          exp_q <= exp_q + 4'd1;
        end else if (restart) begin
          exp_q <= 4'd2;
        end
      end else if (hs) begin
        if (hs_last) begin
          rd_q      <= '0;
          out_valid <= 1'b0;
        end else begin
          rd_q     <= rd_q + 4'd1;
          out_data <= mem_rdata;
          out_row  <= rd_q + 4'd2;
        end
      end
    end
  end

  assign busy = (state == DRAIN);
endmodule

// File: tb/tb_row_buf.sv
// Scoreboard bench for row_buf: main process drives frames and pushes the
// expected drain words; a negedge monitor pops and compares on handshakes.
module tb_row_buf;
  logic        clk = 1'b0;
  logic        rst, load, out_ready, clr_err;
  logic [69:0] din;
  logic [3:0]  row;
  logic        out_valid, frame_done, seq_err, busy;
  logic [69:0] out_data;
  logic [3:0]  out_row;

  typedef struct packed {
    logic [3:0]  row;
    logic [69:0] data;
  } word_t;

  word_t sbq[$];
  int    errors = 0;
  int    checks = 0;

  row_buf dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .row(row),
    .out_ready(out_ready), .clr_err(clr_err), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .frame_done(frame_done),
    .seq_err(seq_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [69:0] dat(input int r, input int k);
    logic [69:0] v;
    v = (70'(k) << 60) | (70'(r) * 70'h111);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [3:0] r, input logic [69:0] d);
    load = 1'b1; row = r; din = d;
    tick();
    load = 1'b0;
  endtask

  task automatic push_frame(input int k);
    word_t w;
    for (int r = 1; r <= 12; r++) begin
      w.row  = 4'(r);
      w.data = dat(r, k);
      sbq.push_back(w);
    end
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (busy && n < 40) begin tick(); n++; end
    chk("drain_done", 80'(busy), 80'(0));
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  // Monitor: scoreboard pops on handshake, stability checked while stalled.
  logic [69:0] prev_data;
  logic [3:0]  prev_row;
  logic        stalled = 1'b0;
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 80'(out_valid), 80'(1));
        chk("stall_data", 80'(out_data), 80'(prev_data));
        chk("stall_row", 80'(out_row), 80'(prev_row));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_word_expected", 80'(sbq.size()), 80'(1));
        end else begin
          e = sbq.pop_front();
          chk("sb_row", 80'(out_row), 80'(e.row));
          chk("sb_data", 80'(out_data), 80'(e.data));
        end
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_row  = out_row;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic       last;
    bit         fell;
    rst = 1'b1; load = 1'b0; din = '0; row = '0; out_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_data", 80'(out_data), 80'(0));
    chk("rst_out_row", 80'(out_row), 80'(0));
    chk("rst_frame_done", 80'(frame_done), 80'(0));
    chk("rst_seq_err", 80'(seq_err), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    rst = 1'b0;
    tick();

    // Frame 1: streaming drain with out_ready held high.
    out_ready = 1'b1;
    push_frame(1);
    for (int r = 1; r <= 12; r++) begin
      chk("fill_valid_low", 80'(out_valid), 80'(0));
      load_word(4'(r), dat(r, 1));
    end
    chk("f1_frame_done", 80'(frame_done), 80'(1));
    chk("f1_busy", 80'(busy), 80'(1));
    for (int i = 1; i <= 12; i++) begin
      chk("f1_valid", 80'(out_valid), 80'(1));
      chk("f1_row_seq", 80'(out_row), 80'(i));
      if (i == 2) chk("f1_frame_done_pulse", 80'(frame_done), 80'(0));
      tick();
    end
    chk("f1_valid_end", 80'(out_valid), 80'(0));
    chk("f1_busy_end", 80'(busy), 80'(0));
    chk("f1_seq_err", 80'(seq_err), 80'(0));

    // Frame 2: ready pattern 1,0,0,1 repeating.
    out_ready = 1'b0;
    push_frame(2);
    for (int r = 1; r <= 12; r++) load_word(4'(r), dat(r, 2));
    pat  = 4'b1001;
    fell = 1'b0;
    for (int i = 0; i < 100 && !fell; i++) begin
      out_ready = pat[i % 4];
      last = out_valid && out_ready && (out_row == 4'd12);
      if (last) chk("f2_busy_before", 80'(busy), 80'(1));
      tick();
      if (last) begin
        chk("f2_busy_fall", 80'(busy), 80'(0));
        chk("f2_valid_fall", 80'(out_valid), 80'(0));
        fell = 1'b1;
      end
    end
    chk("f2_completed", 80'(fell), 80'(1));
    out_ready = 1'b1;

    // Frame 3: rows 1,2,4 (row 4 dropped), then 3..12.
    push_frame(3);
    load_word(4'd1, dat(1, 3));
    load_word(4'd2, dat(2, 3));
    chk("f3_no_err", 80'(seq_err), 80'(0));
    load_word(4'd4, 70'hBAD);
    chk("f3_err_set", 80'(seq_err), 80'(1));
    for (int r = 3; r <= 12; r++) load_word(4'(r), dat(r, 3));
    chk("f3_frame_done", 80'(frame_done), 80'(1));
    drain_all();
    chk("f3_err_sticky", 80'(seq_err), 80'(1));
    clr_pulse();
    chk("f3_err_clr", 80'(seq_err), 80'(0));

    // Frame 4: rows 1..5, restart at row 1, then 2..12.
    push_frame(4);
    for (int r = 1; r <= 5; r++) load_word(4'(r), dat(r, 9));
    chk("f4_no_err", 80'(seq_err), 80'(0));
    load_word(4'd1, dat(1, 4));
    chk("f4_err_restart", 80'(seq_err), 80'(1));
    for (int r = 2; r <= 12; r++) load_word(4'(r), dat(r, 4));
    chk("f4_frame_done", 80'(frame_done), 80'(1));
    drain_all();
    clr_pulse();

    // Frame 5: overrun during a stalled drain, clear and clear/error overlap.
    out_ready = 1'b0;
    push_frame(5);
    for (int r = 1; r <= 12; r++) load_word(4'(r), dat(r, 5));
    load_word(4'd3, 70'h3_DEAD_BEEF);
    chk("f5_overrun_err", 80'(seq_err), 80'(1));
    chk("f5_busy", 80'(busy), 80'(1));
    chk("f5_hold_row", 80'(out_row), 80'(1));
    chk("f5_hold_data", 80'(out_data), 80'(dat(1, 5)));
    clr_pulse();
    chk("f5_err_clr", 80'(seq_err), 80'(0));
    clr_err = 1'b1;
    load_word(4'd7, 70'h7);
    clr_err = 1'b0;
    chk("f5_err_priority", 80'(seq_err), 80'(1));
    clr_pulse();
    chk("f5_err_clr2", 80'(seq_err), 80'(0));
    drain_all();

    // Frame 6: reset mid-fill (with load during reset), then a clean frame.
    for (int r = 1; r <= 7; r++) load_word(4'(r), dat(r, 6));
    load_word(4'd0, 70'h0);
    chk("f6_illegal_row_err", 80'(seq_err), 80'(1));
    rst = 1'b1; load = 1'b1; row = 4'd1; din = 70'h1_2345;
    tick();
    rst = 1'b0; load = 1'b0;
    chk("f6_rst_valid", 80'(out_valid), 80'(0));
    chk("f6_rst_data", 80'(out_data), 80'(0));
    chk("f6_rst_row", 80'(out_row), 80'(0));
    chk("f6_rst_frame_done", 80'(frame_done), 80'(0));
    chk("f6_rst_seq_err", 80'(seq_err), 80'(0));
    chk("f6_rst_busy", 80'(busy), 80'(0));
    push_frame(7);
    for (int r = 1; r <= 12; r++) load_word(4'(r), dat(r, 7));
    chk("f7_frame_done", 80'(frame_done), 80'(1));
    drain_all();
    chk("f7_seq_err", 80'(seq_err), 80'(0));

    tick();
    chk("sb_all_delivered", 80'(sbq.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
